// File: rtl/cp0_exc_ctrl_if.sv
//------------------------------------------------------------------------------
// cp0_exc_ctrl_if
// Bundles the M-stage, MTC0/MFC0 and redirect signals of the CP0 exception
// controller so the pipeline and the controller share one connection.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cp0_exc_ctrl_if;
    logic [31:0] pc_m;
    logic        valid_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic        stall_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cp0_jump;
    logic [31:0] cp0_npc;
    logic        flush;

    // Pipeline side: drives M-stage state and MTC0/MFC0 requests
    modport master (
        output pc_m, valid_m, bd_m, exc_code_m, eret_m, stall_m, hw_int,
               we, addr, wdata,
        input  rdata, cp0_jump, cp0_npc, flush
    );

    // Controller side
    modport slave (
        input  pc_m, valid_m, bd_m, exc_code_m, eret_m, stall_m, hw_int,
               we, addr, wdata,
        output rdata, cp0_jump, cp0_npc, flush
    );
endinterface

`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
//------------------------------------------------------------------------------
// cp0_exc_ctrl
// Minimal MIPS CP0: SR, Cause, EPC, PRId, interrupt/exception entry and ERET.
// Optional feature macro: CP0_BD_DELAY_SLOT_EN (branch-delay-slot capture of
// Cause.BD and EPC = pc_m - 4 for delay-slot instructions).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cp0_exc_ctrl (
    input  wire logic         clk,
    input  wire logic         reset,
    cp0_exc_ctrl_if.slave     bus
);

    localparam logic [31:0] PRID_VALUE = 32'h4D59_4350;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [4:0]  REG_SR     = 5'd12;
    localparam logic [4:0]  REG_CAUSE  = 5'd13;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [4:0]  REG_PRID   = 5'd15;

    // SR fields
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    // Cause fields
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    // EPC
    logic [31:0] epc;

    logic        m_live;
    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        eret_go;
    logic        bd_cap;
    logic [31:0] epc_next;

    // Event qualification; reset masks every redirect in the reset cycle
    always_comb begin
        m_live  = bus.valid_m & ~bus.stall_m & ~reset;
        int_req = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl & m_live;
        exc_req = (bus.exc_code_m != 5'd0) & ~sr_exl & m_live;
        take    = int_req | exc_req;
        eret_go = bus.eret_m & m_live & ~take;
    end

`ifdef CP0_BD_DELAY_SLOT_EN
    // Delay-slot instructions restart at the branch, one word earlier
    always_comb begin
        bd_cap   = bus.bd_m;
        epc_next = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end
`else
    // Without delay-slot support the faulting PC itself is the restart point
    always_comb begin
        bd_cap   = 1'b0;
        epc_next = bus.pc_m;
    end
`endif

    // Redirect outputs: exception vector on entry, EPC on ERET, else idle
    always_comb begin
        bus.cp0_jump = take | eret_go;
        bus.flush    = take | eret_go;
        if (take) begin
            bus.cp0_npc = EXC_VECTOR;
        end else if (eret_go) begin
            bus.cp0_npc = epc;
        end else begin
            bus.cp0_npc = 32'd0;
        end
    end

    // MFC0 read mux; unimplemented registers and SR/Cause holes read 0
    always_comb begin
        case (bus.addr)
            REG_SR:    bus.rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            REG_CAUSE: bus.rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            REG_EPC:   bus.rdata = epc;
            REG_PRID:  bus.rdata = PRID_VALUE;
            default:   bus.rdata = 32'd0;
        endcase
    end

    // CP0 state: IP sampling, exception entry, ERET, then MTC0 at lowest priority
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= bus.hw_int;
            if (take) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : bus.exc_code_m;
                cause_bd  <= bd_cap;
                epc       <= {epc_next[31:2], 2'b00};
            end else if (eret_go) begin
                sr_exl <= 1'b0;
            end else if (bus.we) begin
                if (bus.addr == REG_SR) begin
                    sr_im  <= bus.wdata[15:10];
                    sr_exl <= bus.wdata[1];
                    sr_ie  <= bus.wdata[0];
                end else if (bus.addr == REG_EPC) begin
                    epc <= {bus.wdata[31:2], 2'b00};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
//------------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Directed scoreboard bench for cp0_exc_ctrl. Honours CP0_BD_DELAY_SLOT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cp0_exc_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic        jump;
        logic [31:0] npc;
        logic [31:0] rd;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];

`ifdef CP0_BD_DELAY_SLOT_EN
    localparam logic [31:0] EPC_038   = 32'h0000_300C;
    localparam logic [31:0] CAUSE_038 = 32'h8000_0030;
`else
    localparam logic [31:0] EPC_038   = 32'h0000_3010;
    localparam logic [31:0] CAUSE_038 = 32'h0000_0030;
`endif

    localparam logic [31:0] VEC  = 32'h0000_4180;
    localparam logic [31:0] PRID = 32'h4D59_4350;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter ties each expectation to the cycle it was issued in
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compares the DUT outputs of a cycle against its queued expectation
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors = vectors + 1;
            if (bus.cp0_jump !== e.jump || bus.flush !== e.jump ||
                bus.cp0_npc !== e.npc || bus.rdata !== e.rd) begin
                miscompares = miscompares + 1;
                $display("FAIL %s cyc=%0d: got jump=%0b flush=%0b npc=%h rdata=%h, expected jump=%0b flush=%0b npc=%h rdata=%h",
                         e.tag, cyc, bus.cp0_jump, bus.flush, bus.cp0_npc, bus.rdata,
                         e.jump, e.jump, e.npc, e.rd);
            end
        end
    end

    // One stimulus cycle: drive inputs after the edge and queue the expectation
    task automatic step(input logic rst, input logic [31:0] pc, input logic v,
                        input logic bd, input logic [4:0] exc, input logic er,
                        input logic st, input logic [5:0] hw, input logic w,
                        input logic [4:0] a, input logic [31:0] wd,
                        input logic ej, input logic [31:0] enpc,
                        input logic [31:0] erd, input logic [63:0] tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.pc_m       = pc;
        bus.valid_m    = v;
        bus.bd_m       = bd;
        bus.exc_code_m = exc;
        bus.eret_m     = er;
        bus.stall_m    = st;
        bus.hw_int     = hw;
        bus.we         = w;
        bus.addr       = a;
        bus.wdata      = wd;
        e.cyc  = cyc;
        e.jump = ej;
        e.npc  = enpc;
        e.rd   = erd;
        e.tag  = tag;
        q.push_back(e);
    endtask

    // Idle read of a CP0 register
    task automatic rd(input logic [4:0] a, input logic [31:0] erd, input logic [63:0] tag);
        step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, a, 32'd0,
             1'b0, 32'd0, erd, tag);
    endtask

    // Idle MTC0 write; rdata shows the pre-write value of the same register
    task automatic wr(input logic [4:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic [63:0] tag);
        step(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, a, wd,
             1'b0, 32'd0, erd, tag);
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        reset          = 1'b1;
        bus.pc_m       = 32'd0;
        bus.valid_m    = 1'b0;
        bus.bd_m       = 1'b0;
        bus.exc_code_m = 5'd0;
        bus.eret_m     = 1'b0;
        bus.stall_m    = 1'b0;
        bus.hw_int     = 6'd0;
        bus.we         = 1'b0;
        bus.addr       = 5'd0;
        bus.wdata      = 32'd0;

        // Reset and PRId
        step(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5'd15, 32'd0,
             1'b0, 32'd0, PRID, "rst_prid");
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_caus");
        rd(5'd14, 32'd0, "rst_epc");
        rd(5'd7,  32'd0, "unimpl");

        // Enable IM[0] and IE
        wr(5'd12, 32'hFFFF_0401, 32'd0, "mtc0_sr");
        rd(5'd12, 32'h0000_0401, "sr_rd");

        // Interrupt entry
        step(1'b0, 32'h3008, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000001, 1'b0, 5'd12, 32'd0,
             1'b1, VEC, 32'h0000_0401, "int_take");
        rd(5'd13, 32'h0000_0400, "int_caus");
        rd(5'd12, 32'h0000_0403, "int_exl");
        rd(5'd14, 32'h0000_3008, "int_epc");

        // EXL masks both interrupt and exception
        step(1'b0, 32'h3100, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 6'b000001, 1'b0, 5'd14, 32'd0,
             1'b0, 32'd0, 32'h0000_3008, "exl_mask");
        step(1'b0, 32'h3104, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 1'b0, 5'd12, 32'd0,
             1'b1, 32'h3008, 32'h0000_0403, "eret1");
        rd(5'd12, 32'h0000_0401, "eret1_sr");

        // Exception in a delay slot
        step(1'b0, 32'h3010, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0,
             1'b1, VEC, 32'd0, "exc_take");
        rd(5'd14, EPC_038,   "bd_epc");
        rd(5'd13, CAUSE_038, "bd_caus");

        // MTC0 EPC while EXL=1, then ERET to it
        wr(5'd14, 32'h0000_300C, EPC_038, "mtc0_epc");
        step(1'b0, 32'h3200, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0,
             1'b1, 32'h300C, 32'h0000_300C, "eret2");
        rd(5'd12, 32'h0000_0401, "eret2_sr");

        // Interrupt plus exception, held by a stall first
        step(1'b0, 32'h3020, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1, 6'b000001, 1'b0, 5'd12, 32'd0,
             1'b0, 32'd0, 32'h0000_0401, "stall1");
        step(1'b0, 32'h3020, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1, 6'b000001, 1'b0, 5'd12, 32'd0,
             1'b0, 32'd0, 32'h0000_0401, "stall2");
        step(1'b0, 32'h3020, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 6'b000001, 1'b0, 5'd12, 32'd0,
             1'b1, VEC, 32'h0000_0401, "prio_tk");
        rd(5'd13, 32'h0000_0400, "prio_cs");
        step(1'b0, 32'h3300, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 1'b0, 5'd14, 32'd0,
             1'b1, 32'h3020, 32'h0000_3020, "eret3");

        // MTC0 dropped in a take cycle, committed when idle
        step(1'b0, 32'h3030, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000001, 1'b1, 5'd14, 32'h3457,
             1'b1, VEC, 32'h0000_3020, "wr_take");
        rd(5'd14, 32'h0000_3030, "wr_drop");
        step(1'b0, 32'h3400, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 1'b1, 5'd14, 32'h1111,
             1'b1, 32'h3030, 32'h0000_3030, "wr_eret");
        rd(5'd14, 32'h0000_3030, "wr_drop2");
        wr(5'd14, 32'h0000_3457, 32'h0000_3030, "wr_idle");
        rd(5'd14, 32'h0000_3454, "wr_comm");

        // Reset in a would-be take cycle
        step(1'b1, 32'h3040, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 6'b000001, 1'b0, 5'd12, 32'd0,
             1'b0, 32'd0, 32'h0000_0401, "rst_take");
        rd(5'd12, 32'd0, "rst2_sr");
        rd(5'd14, 32'd0, "rst2_epc");
        rd(5'd13, 32'd0, "rst2_cs");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
